hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Pipeline hazard and forwarding controller for the 5-stage RISC-V core.
- Tracks the destination and write-enable of the instructions in EX, MEM and WB. Produces the registered 2-bit operand selects that drive the two EX-stage 3:1 operand muxes (data_0 = register file, data_1 = WB result, data_2 = MEM ALU result).
- Detects load-use hazards, issues the stall and bubble, applies branch flushes, and counts load-use stalls.

Parameters:
REG_ADDR_W, 5, register-address width
CNT_W, 16, width of the load-use stall counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
pipe_en  input  1  global pipeline advance; 0 freezes all tracking state
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_ADDR_W  ID source register 1
id_rs2  input  REG_ADDR_W  ID source register 2
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_W  ID destination register
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch or jump this cycle
forward_a  output  2  EX operand-A mux select, registered
forward_b  output  2  EX operand-B mux select, registered
stall  output  1  hold PC and IF/ID register, combinational
flush_if_id  output  1  zero the IF/ID register, combinational
flush_id_ex  output  1  insert a bubble into ID/EX, combinational
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset (async, rst_n=0):
  - All tracking valid bits = 0.
  - forward_a = forward_b = 2'b00.
  - stall_count = 0.
  - Combinational outputs then evaluate to 0 unless ex_branch_taken=1.
- Tracking registers: ex_{valid,rd,rw,mr}, mem_{valid,rd,rw}, wb_{valid,rd,rw}. They advance on a clk edge only when pipe_en=1:
  - wb <- mem.
  - mem <- ex.
  - ex <- ID fields, but ex_valid <- id_valid & ~flush_id_ex.
- A stage "writes r" iff valid & rw & rd==r & r!=0. Register x0 never matches.
- load_use = id_valid & ex_valid & ex_mr & ex_rw & ex_rd!=0 & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
- Combinational outputs:
  - stall = load_use & ~ex_branch_taken.
  - flush_if_id = ex_branch_taken.
  - flush_id_ex = stall | ex_branch_taken.
  - A taken branch has priority over a load-use stall.
- Forward selects are computed for the ID instruction and registered when pipe_en=1 & ~flush_id_ex, so they are valid in the cycle that instruction is in EX:
  - 2'b10 if EX writes rsN and is not a load (the producer will be in MEM).
  - Else 2'b01 if MEM writes rsN (the producer will be in WB).
  - Else 2'b00.
  - The nearer producer wins. Registers with uses_rsN=0 get 2'b00.
  - 2'b11 is never driven.
- When flush_id_ex=1 and pipe_en=1, forward_a and forward_b are loaded with 2'b00 (the bubble uses the register path).
- After a 1-cycle load-use stall, the load has moved to MEM. Re-evaluation yields 2'b01, and the consumer reads the WB load data. Maximum stall per load is 1 cycle.
- pipe_en=0:
  - All registers hold, including forward_a, forward_b and stall_count.
  - The combinational outputs still reflect current state.
- stall_count increments by 1 on each clk edge where pipe_en=1 and stall=1. It saturates at all-ones and never wraps.
- The register file provides same-cycle WB-to-read bypass, so WB-to-ID distance-3 hazards need no action here.
- Reset asserted mid-stall: the stall and all tracking are cleared immediately. After release, there is no pending hazard and the first instruction sees 2'b00.

Decomposition:
- Shared package riscv_pkg:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_ADDR_W default.
  - A stage-tracking struct typedef {valid, rd, rw, mr}.
- One natural sub-module: fwd_sel_calc, a pure-combinational priority compare for one source register. Instantiate it twice (rs1, rs2).

Test Plan:
- add x5 in EX (rw=1, mr=0); ID add x6,x5,x1 with uses_rs1=1, pipe_en=1 -> next cycle forward_a=2'b10, forward_b=2'b00, stall=0.
- x5 producer in MEM, nothing in EX matches; ID uses x5 as rs2 -> next cycle forward_b=2'b01. Repeat with both EX and MEM writing x5 -> forward_b=2'b10 (nearer wins).
- lw x6 in EX (mr=1); ID add x7,x6,x6 ->
  - Cycle 0: stall=1, flush_id_ex=1.
  - Cycle 1: stall=0, ex_valid=0, stall_count=1.
  - Cycle 2: forward_a=forward_b=2'b01.
- Same load-use with ex_branch_taken=1 in cycle 0 -> stall=0, flush_if_id=1, flush_id_ex=1, stall_count stays 0.
- Producer writes x0 in EX and MEM; ID reads x0 -> forward_a=forward_b=2'b00, stall=0.
- Hold the load-use condition with pipe_en=0 for 3 cycles -> registers and stall_count frozen. Assert rst_n=0 mid-stall -> stall=0, stall_count=0, forward_a=forward_b=2'b00 with no clock edge. Preload counter near max with repeated stalls -> saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline control blocks.
//   fwd_sel_e : EX operand mux select encoding
//               (register file / WB result / MEM ALU result)
//   stage_t   : per-stage tracking record {valid, rd, rw, mr}
//   stage_writes() : true when a tracked stage will write a given register
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rw;
        logic                  mr;
    } stage_t;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic stage_writes(input stage_t s,
                                          input logic [REG_ADDR_W-1:0] r);
        return s.valid & s.rw & (s.rd == r) & (r != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding priority compare for one ID-stage source register.
//   uses_rs   : ID instruction actually reads this source
//   rs        : source register address
//   ex_stage  : tracking record of the instruction currently in EX
//   mem_stage : tracking record of the instruction currently in MEM
//   sel       : operand select to apply once the ID instruction reaches EX
//   load_hit  : the EX instruction is a load producing this source
module fwd_sel_calc
    import riscv_pkg::*;
(
    input  logic                  uses_rs,
    input  logic [REG_ADDR_W-1:0] rs,
    input  stage_t                ex_stage,
    input  stage_t                mem_stage,
    output fwd_sel_e              sel,
    output logic                  load_hit
);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit   = uses_rs & stage_writes(ex_stage, rs);
        mem_hit  = uses_rs & stage_writes(mem_stage, rs);
        load_hit = ex_hit & ex_stage.mr;

        // Selection is one stage ahead: the EX producer will sit in MEM and
        // the MEM producer in WB when the consumer is in EX. A load in EX
        // has no data yet, so it is left to the load-use stall.
        sel = FWD_REG;
        if (ex_hit && !ex_stage.mr) begin
            sel = FWD_MEM;
        end else if (mem_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding control for the 5-stage core.
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   pipe_en             : pipeline advance; 0 freezes all state
//   id_*                : decoded fields of the instruction in ID
//   ex_branch_taken     : EX resolved a taken branch/jump this cycle
//   forward_a/forward_b : registered EX operand mux selects
//   stall               : hold PC and IF/ID (load-use)
//   flush_if_id         : zero IF/ID (taken branch)
//   flush_id_ex         : bubble into ID/EX (stall or taken branch)
//   stall_count         : saturating count of load-use stall cycles
module hazard_fwd_unit
    import riscv_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = riscv_pkg::REG_ADDR_W,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t   ex_q;
    stage_t   mem_q;
    stage_t   wb_q;
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;
    logic     hit_a;
    logic     hit_b;
    logic     load_use;

    fwd_sel_calc u_fwd_a (
        .uses_rs   (id_uses_rs1),
        .rs        (id_rs1),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .sel       (sel_a),
        .load_hit  (hit_a)
    );

    fwd_sel_calc u_fwd_b (
        .uses_rs   (id_uses_rs2),
        .rs        (id_rs2),
        .ex_stage  (ex_q),
        .mem_stage (mem_q),
        .sel       (sel_b),
        .load_hit  (hit_b)
    );

    always_comb begin
        load_use    = id_valid & (hit_a | hit_b);
        // A taken branch kills the consumer anyway, so it overrides the stall.
        stall       = load_use & ~ex_branch_taken;
        flush_if_id = ex_branch_taken;
        flush_id_ex = stall | ex_branch_taken;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            forward_a   <= FWD_REG;
            forward_b   <= FWD_REG;
            stall_count <= '0;
        end else if (pipe_en) begin
            wb_q     <= mem_q;
            mem_q    <= ex_q;
            ex_q.valid <= id_valid & ~flush_id_ex;
            ex_q.rd    <= id_rd;
            ex_q.rw    <= id_reg_write;
            ex_q.mr    <= id_mem_read;

            // A bubble entering EX reads the register file path.
            if (flush_id_ex) begin
                forward_a <= FWD_REG;
                forward_b <= FWD_REG;
            end else begin
                forward_a <= sel_a;
                forward_b <= sel_b;
            end

            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_en = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_uses_rs1 = 1'b0;
    logic          id_uses_rs2 = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_reg_write = 1'b0;
    logic          id_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic [1:0]    forward_a;
    logic [1:0]    forward_b;
    logic          stall;
    logic          flush_if_id;
    logic          flush_id_ex;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pipe_en         (pipe_en),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .stall_count     (stall_count)
    );

    typedef struct {
        string         tag;
        logic          chk_fwd;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic u1, input logic u2, input logic [AW-1:0] rd,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic check_comb(input string tag, input logic s, input logic fi, input logic fe);
        check_eq({tag, ".stall"},       32'(stall),       32'(s));
        check_eq({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fi));
        check_eq({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fe));
    endtask

    task automatic expect_reg(input string tag, input logic cf, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [CW-1:0] cnt);
        exp_t e;
        e.tag = tag; e.chk_fwd = cf; e.fa = fa; e.fb = fb; e.cnt = cnt;
        sbq.push_back(e);
    endtask

    // One clock edge, then compare registered outputs against the oldest entry.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            if (e.chk_fwd) begin
                check_eq({e.tag, ".forward_a"}, 32'(forward_a), 32'(e.fa));
                check_eq({e.tag, ".forward_b"}, 32'(forward_b), 32'(e.fb));
            end
            check_eq({e.tag, ".stall_count"}, 32'(stall_count), 32'(e.cnt));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        // Reset state
        #2;
        check_eq("rst.forward_a", 32'(forward_a), 32'(2'b00));
        check_eq("rst.forward_b", 32'(forward_b), 32'(2'b00));
        check_eq("rst.stall_count", 32'(stall_count), 32'd0);
        check_comb("rst", 1'b0, 1'b0, 1'b0);
        #5;
        rst_n   = 1'b1;
        pipe_en = 1'b1;

        // EX -> operand A forwarding
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        check_comb("A", 1'b0, 1'b0, 1'b0);
        expect_reg("A", 1'b1, 2'b00, 2'b00, 4'd0); tick();
        set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        check_comb("B", 1'b0, 1'b0, 1'b0);
        expect_reg("B", 1'b1, 2'b10, 2'b00, 4'd0); tick();

        // MEM -> operand B forwarding
        set_id(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        expect_reg("C", 1'b1, 2'b00, 2'b01, 4'd0); tick();

        // EX and MEM both write x5: nearer wins; uses=0 ignores matches
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        expect_reg("D", 1'b1, 2'b00, 2'b00, 4'd0); tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
        expect_reg("E", 1'b1, 2'b00, 2'b00, 4'd0); tick();
        set_id(1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        expect_reg("F", 1'b1, 2'b00, 2'b10, 4'd0); tick();

        // Load-use: one stall cycle, then forwarding from WB
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1);
        check_comb("G", 1'b0, 1'b0, 1'b0);
        expect_reg("G", 1'b1, 2'b00, 2'b00, 4'd0); tick();
        set_id(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        check_comb("H", 1'b1, 1'b0, 1'b1);
        expect_reg("H", 1'b1, 2'b00, 2'b00, 4'd1); tick();
        #1;
        check_comb("I", 1'b0, 1'b0, 1'b0);
        expect_reg("I", 1'b1, 2'b01, 2'b01, 4'd1); tick();

        // Load-use coinciding with a taken branch
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
        expect_reg("J", 1'b1, 2'b00, 2'b00, 4'd1); tick();
        ex_branch_taken = 1'b1;
        set_id(1'b1, 5'd9, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        check_comb("K", 1'b0, 1'b1, 1'b1);
        expect_reg("K", 1'b1, 2'b00, 2'b00, 4'd1); tick();
        ex_branch_taken = 1'b0;

        // x0 producers (including a load) never match
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
        expect_reg("L", 1'b1, 2'b00, 2'b00, 4'd1); tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        expect_reg("M", 1'b1, 2'b00, 2'b00, 4'd1); tick();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        check_comb("N", 1'b0, 1'b0, 1'b0);
        expect_reg("N", 1'b1, 2'b00, 2'b00, 4'd1); tick();

        // Freeze during a load-use, then reset mid-stall
        set_id(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd10, 1'b1, 1'b1);
        expect_reg("O", 1'b1, 2'b00, 2'b10, 4'd1); tick();
        pipe_en = 1'b0;
        set_id(1'b1, 5'd10, 5'd3, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_comb("P", 1'b1, 1'b0, 1'b1);
            expect_reg("P", 1'b1, 2'b00, 2'b10, 4'd1); tick();
        end
        pipe_en = 1'b1;
        #1;
        check_comb("P_live", 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_comb("rst_mid", 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid.forward_a", 32'(forward_a), 32'(2'b00));
        check_eq("rst_mid.forward_b", 32'(forward_b), 32'(2'b00));
        check_eq("rst_mid.stall_count", 32'(stall_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check_comb("Q", 1'b0, 1'b0, 1'b0);
        expect_reg("Q", 1'b1, 2'b00, 2'b00, 4'd0); tick();

        // Self-dependent load repeats: stall every other cycle until saturation
        set_id(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            check_comb("SAT", logic'(k % 2 == 1), 1'b0, logic'(k % 2 == 1));
            e = (k + 1) / 2;
            if (e > 15) e = 15;
            expect_reg("SAT", 1'b0, 2'b00, 2'b00, CW'(e)); tick();
        end

        check_eq("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
